snn_image_sequencer: RTL

Sequences one inference of the SNN coprocessor. It detects a new-image request from the AXI4-Lite register block and streams the 256 stored pixels into the SNN core with a valid/ready handshake. It then issues a start pulse, waits for the core's done flag and holds the inferred digit for AXI readback. It sits between the AXI4-Lite slave and the SNN core.

---
 rtl/snn_seq_pkg.sv | 14 +
 rtl/snn_seq_timeout.sv | 28 ++
 rtl/snn_image_sequencer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/snn_seq_pkg.sv
// Shared types and constants for the SNN image sequencer.
package snn_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        START = 2'd2,
        WAIT  = 2'd3
    } seq_state_e;

    // Digit reported when the core never signals completion.
    localparam logic [7:0] DIGIT_TIMEOUT = '1;

endpackage

// File: rtl/snn_seq_timeout.sv
// WAIT-phase watchdog: 16-bit counter with clear, enable and terminal flag.
// Compiled only when SNN_SEQ_TIMEOUT_EN is defined.
`ifdef SNN_SEQ_TIMEOUT_EN
module snn_seq_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic ACLK,
    input  logic ARESETN,
    input  logic clr_i,
    input  logic en_i,
    output logic term_o
);

    logic [15:0] cnt_q;

    // Saturates on the terminal value so a held enable cannot wrap.
    always_ff @(posedge ACLK) begin
        if (!ARESETN || clr_i) begin
            cnt_q <= '0;
        end else if (en_i && !term_o) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign term_o = (cnt_q == 16'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/snn_image_sequencer.sv
// Runs one SNN inference: streams the stored image into the core, pulses start, captures the digit.
// Optional WAIT watchdog compiled in with SNN_SEQ_TIMEOUT_EN.
module snn_image_sequencer
    import snn_seq_pkg::*;
#(
    parameter int N          = 256,
    parameter int M          = $clog2(N),
    parameter int IMAGE_SIZE = 256,
    parameter int PIXEL_BITS = 8
`ifdef SNN_SEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 65535
`endif
) (
    input  logic                                  ACLK,
    input  logic                                  ARESETN,
    input  logic                                  NEW_IMAGE,
    input  logic [IMAGE_SIZE-1:0][PIXEL_BITS-1:0] IMAGE,
    output logic                                  PIX_VALID,
    output logic [M-1:0]                          PIX_ADDR,
    output logic [PIXEL_BITS-1:0]                 PIX_VALUE,
    input  logic                                  PIX_READY,
    output logic                                  SNN_START,
    input  logic                                  SNN_DONE,
    input  logic [M-1:0]                          SNN_DIGIT,
    output logic [M-1:0]                          INFERED_DIGIT,
    output logic                                  RESULT_VALID,
    output logic                                  BUSY,
    output logic                                  TIMEOUT_ERR
);

    seq_state_e      state_q;
    logic            new_image_q;
    logic            pending_q;
    logic            pix_valid_q;
    logic [M-1:0]    pix_addr_q;
    logic            snn_start_q;
    logic [M-1:0]    digit_q;
    logic            result_valid_q;
    logic            busy_q;
    logic            timeout_err_q;

    logic            req_d;
    logic            last_pix_d;

    assign req_d      = NEW_IMAGE && !new_image_q;
    assign last_pix_d = (pix_addr_q == M'(IMAGE_SIZE - 1));

`ifdef SNN_SEQ_TIMEOUT_EN
    logic tmo_term;

    snn_seq_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .clr_i   (state_q == START),
        .en_i    (state_q == WAIT),
        .term_o  (tmo_term)
    );
`endif

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q        <= IDLE;
            new_image_q    <= 1'b0;
            pending_q      <= 1'b0;
            pix_valid_q    <= 1'b0;
            pix_addr_q     <= '0;
            snn_start_q    <= 1'b0;
            digit_q        <= '0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            new_image_q <= NEW_IMAGE;
            snn_start_q <= 1'b0;
            // Requests arriving while busy collapse into a single deferred run.
            if (req_d && state_q != IDLE) begin
                pending_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (req_d || pending_q) begin
                        state_q        <= LOAD;
                        pix_valid_q    <= 1'b1;
                        pix_addr_q     <= '0;
                        result_valid_q <= 1'b0;
                        timeout_err_q  <= 1'b0;
                        pending_q      <= 1'b0;
                        busy_q         <= 1'b1;
                    end
                end
                LOAD: begin
                    if (PIX_READY) begin
                        pix_addr_q <= pix_addr_q + M'(1);
                        if (last_pix_d) begin
                            pix_valid_q <= 1'b0;
                            snn_start_q <= 1'b1;
                            state_q     <= START;
                        end
                    end
                end
                START: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (SNN_DONE) begin
                        digit_q        <= SNN_DIGIT;
                        result_valid_q <= 1'b1;
                        busy_q         <= 1'b0;
                        state_q        <= IDLE;
                    end
`ifdef SNN_SEQ_TIMEOUT_EN
                    else if (tmo_term) begin
                        digit_q        <= M'(DIGIT_TIMEOUT);
                        result_valid_q <= 1'b1;
                        timeout_err_q  <= 1'b1;
                        busy_q         <= 1'b0;
                        state_q        <= IDLE;
                    end
`endif
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign PIX_VALID     = pix_valid_q;
    assign PIX_ADDR      = pix_addr_q;
    assign PIX_VALUE     = IMAGE[pix_addr_q];
    assign SNN_START     = snn_start_q;
    assign INFERED_DIGIT = digit_q;
    assign RESULT_VALID  = result_valid_q;
    assign BUSY          = busy_q;
    assign TIMEOUT_ERR   = timeout_err_q;

endmodule
